// File: rtl/kavach_adc_sequencer.sv
// Shares one SAR ADC between the VDD and IDD sense channels. Each pair is published
// as a coherent V/I pair at a programmable rate, and conversion timeouts are flagged.
module kavach_adc_sequencer #(
    parameter int ADC_WIDTH     = 12,
    parameter int PERIOD_WIDTH  = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int CONV_TIMEOUT  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period_cfg,
    input  logic                    err_clr,
    output logic                    adc_chan,
    output logic                    adc_start,
    input  logic                    adc_done,
    input  logic [ADC_WIDTH-1:0]    adc_data,
    output logic [ADC_WIDTH-1:0]    vdd_sample,
    output logic [ADC_WIDTH-1:0]    idd_sample,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [15:0]             sample_count
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CONV_TIMEOUT) ? SETTLE_CYCLES : CONV_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(CONV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE_V,
        CONV_V,
        SETTLE_I,
        CONV_I,
        PUBLISH,
        WAIT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cyc_cnt;
    logic [PERIOD_WIDTH-1:0] period_cnt;
    logic [ADC_WIDTH-1:0]    vdd_hold;
    logic                    in_conv;
    logic                    in_settle;
    logic                    done_ok;
    logic                    conv_tmo;
    logic                    settle_end;
    logic                    seq_start;

    assign in_conv    = (state == CONV_V) || (state == CONV_I);
    assign in_settle  = (state == SETTLE_V) || (state == SETTLE_I);
    // cyc_cnt==0 is the adc_start cycle; a done seen there cannot belong to this conversion
    assign done_ok    = in_conv && adc_done && (cyc_cnt != '0);
    assign conv_tmo   = in_conv && !done_ok && (cyc_cnt == TMO_LAST);
    assign settle_end = in_settle && (cyc_cnt == SETTLE_LAST);
    assign seq_start  = (state_nxt == SETTLE_V) && (state != SETTLE_V);

    always_comb begin
        state_nxt    = state;
        adc_chan     = 1'b0;
        adc_start    = 1'b0;
        sample_valid = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (enable) state_nxt = SETTLE_V;
            end
            SETTLE_V: begin
                if (settle_end) state_nxt = CONV_V;
            end
            CONV_V: begin
                adc_start = (cyc_cnt == '0);
                if (done_ok)       state_nxt = SETTLE_I;
                else if (conv_tmo) state_nxt = WAIT;
            end
            SETTLE_I: begin
                adc_chan = 1'b1;
                if (settle_end) state_nxt = CONV_I;
            end
            CONV_I: begin
                adc_chan  = 1'b1;
                adc_start = (cyc_cnt == '0);
                if (done_ok)       state_nxt = PUBLISH;
                else if (conv_tmo) state_nxt = WAIT;
            end
            PUBLISH: begin
                sample_valid = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (period_cnt == '0) state_nxt = enable ? SETTLE_V : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            period_cnt   <= '0;
            vdd_hold     <= '0;
            vdd_sample   <= '0;
            idd_sample   <= '0;
            timeout_err  <= 1'b0;
            sample_count <= '0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state)        cyc_cnt <= '0;
            else if (in_conv || in_settle) cyc_cnt <= cyc_cnt + 1'b1;

            // the spacing of a pair starts at its SETTLE_V entry, so the load happens there
            if (seq_start)
                period_cnt <= (period_cfg == '0) ? '0 : period_cfg - 1'b1;
            else if (period_cnt != '0)
                period_cnt <= period_cnt - 1'b1;

            if ((state == CONV_V) && done_ok)
                vdd_hold <= adc_data;

            // both outputs move together on the way into PUBLISH, so no half pair is exposed
            if ((state == CONV_I) && done_ok) begin
                vdd_sample   <= vdd_hold;
                idd_sample   <= adc_data;
                sample_count <= sample_count + 16'd1;
            end

            if (conv_tmo)     timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kavach_adc_sequencer.sv
// Bench for kavach_adc_sequencer: a responding ADC model plus pulse/start monitors,
// checked against spacing and pair rules computed directly from the behaviour description.
module tb_kavach_adc_sequencer;

    localparam int AW     = 12;
    localparam int PW     = 16;
    localparam int SETTLE = 4;
    localparam int TMO    = 64;
    localparam logic [AW-1:0] V_FIX = 12'd2048;
    localparam logic [AW-1:0] I_FIX = 12'd1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          err_clr = 1'b0;
    logic          adc_done = 1'b0;
    logic [PW-1:0] period_cfg = '0;
    logic [AW-1:0] adc_data = '0;
    logic          adc_chan, adc_start, sample_valid, busy, timeout_err;
    logic [AW-1:0] vdd_sample, idd_sample;
    logic [15:0]   sample_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // ADC model controls and state
    int            conv_len = 10;
    bit            rand_data = 0;
    bit            glitch = 0;
    bit            idd_never = 0;
    bit            tb_owns_done = 0;
    bit            pend = 0;
    int            pend_wait = 0;
    logic          pend_chan = 1'b0;
    logic [AW-1:0] last_v = '0;
    logic [AW-1:0] last_i = '0;

    // monitor queues
    int            pulse_cyc[$];
    int            pulse_n[$];
    logic [AW-1:0] pulse_v[$];
    logic [AW-1:0] pulse_i[$];
    logic [AW-1:0] pulse_ev[$];
    logic [AW-1:0] pulse_ei[$];
    int            start_cyc[$];
    logic          start_chan[$];

    kavach_adc_sequencer #(
        .ADC_WIDTH(AW), .PERIOD_WIDTH(PW), .SETTLE_CYCLES(SETTLE), .CONV_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .period_cfg(period_cfg), .err_clr(err_clr),
        .adc_chan(adc_chan), .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
        .vdd_sample(vdd_sample), .idd_sample(idd_sample), .sample_valid(sample_valid),
        .busy(busy), .timeout_err(timeout_err), .sample_count(sample_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC: the conversion occupies conv_len cycles counting the start cycle; data is junk otherwise
    always @(negedge clk) begin
        if (!tb_owns_done) begin
            adc_done = 1'b0;
            adc_data = AW'($urandom);
            if (pend) begin
                if (pend_wait == 0) begin
                    pend     = 1'b0;
                    adc_done = 1'b1;
                    if (pend_chan) begin
                        adc_data = rand_data ? AW'($urandom) : I_FIX;
                        last_i   = adc_data;
                    end else begin
                        adc_data = rand_data ? AW'($urandom) : V_FIX;
                        last_v   = adc_data;
                    end
                end else begin
                    pend_wait = pend_wait - 1;
                end
            end
            if (adc_start === 1'b1 && !(idd_never && adc_chan === 1'b1)) begin
                pend      = 1'b1;
                pend_wait = conv_len - 2;
                pend_chan = adc_chan;
                if (glitch) adc_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_v.push_back(vdd_sample);
            pulse_i.push_back(idd_sample);
            pulse_n.push_back(int'(sample_count));
            pulse_ev.push_back(last_v);
            pulse_ei.push_back(last_i);
        end
        if (adc_start === 1'b1) begin
            start_cyc.push_back(cyc);
            start_chan.push_back(adc_chan);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // pair spacing: the configured period, but never less than one full sequence
    function automatic int exp_gap(int p, int lat);
        int m;
        m = 2 * SETTLE + 2 * lat + 2;
        return (p > m) ? p : m;
    endfunction

    task automatic clear_mon();
        pulse_cyc.delete(); pulse_n.delete(); pulse_v.delete(); pulse_i.delete();
        pulse_ev.delete(); pulse_ei.delete(); start_cyc.delete(); start_chan.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; err_clr = 1'b0; idd_never = 0; tb_owns_done = 0;
        glitch = 0; pend = 1'b0; adc_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int b;
        b = budget;
        while (pulse_cyc.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({adc_chan, adc_start, sample_valid, busy, timeout_err} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {adc_chan, adc_start, sample_valid, busy, timeout_err});
        else n_pass++;
        n_checks++;
        if ({vdd_sample, idd_sample, sample_count} !== '0)
            $display("FAIL reset_data got %h/%h/%0d want 0/0/0", vdd_sample, idd_sample, sample_count);
        else n_pass++;
        rst = 1'b0;
        clear_mon();
        repeat (20) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || start_cyc.size() != 0)
            $display("FAIL idle_hold got busy=%b starts=%0d want 0/0", busy, start_cyc.size());
        else n_pass++;
    endtask

    task automatic test_periodic();
        logic [3:0] chans;
        do_reset();
        conv_len = 10; rand_data = 0; period_cfg = 16'd100; enable = 1'b1;
        wait_pulses(3, 400);
        n_checks++;
        if (pulse_cyc.size() < 3) $display("FAIL periodic_pulses got %0d want 3", pulse_cyc.size());
        else n_pass++;
        if (pulse_cyc.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (pulse_v[k] !== V_FIX || pulse_i[k] !== I_FIX)
                    $display("FAIL periodic_pair[%0d] got %0d/%0d want %0d/%0d", k, pulse_v[k], pulse_i[k], V_FIX, I_FIX);
                else n_pass++;
                n_checks++;
                if (pulse_n[k] != k + 1)
                    $display("FAIL periodic_count[%0d] got %0d want %0d", k, pulse_n[k], k + 1);
                else n_pass++;
            end
            for (int k = 1; k < 3; k++) begin
                n_checks++;
                if (pulse_cyc[k] - pulse_cyc[k-1] != 100)
                    $display("FAIL periodic_gap[%0d] got %0d want 100", k, pulse_cyc[k] - pulse_cyc[k-1]);
                else n_pass++;
            end
        end
        n_checks++;
        if (busy !== 1'b1) $display("FAIL periodic_busy got %b want 1", busy);
        else n_pass++;
        chans = {start_chan[0], start_chan[1], start_chan[2], start_chan[3]};
        n_checks++;
        if (chans !== 4'b0101) $display("FAIL chan_order got %b want 0101", chans);
        else n_pass++;
        // current WAIT keeps the old period; the new one applies from the next pair
        period_cfg = 16'd60;
        wait_pulses(5, 300);
        n_checks++;
        if (pulse_cyc.size() < 5) $display("FAIL period_change_pulses got %0d want 5", pulse_cyc.size());
        else if (pulse_cyc[3] - pulse_cyc[2] != 100 || pulse_cyc[4] - pulse_cyc[3] != 60)
            $display("FAIL period_change got %0d,%0d want 100,60", pulse_cyc[3] - pulse_cyc[2], pulse_cyc[4] - pulse_cyc[3]);
        else n_pass++;
    endtask

    task automatic test_min_period();
        int lat, p, g;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            lat = $urandom_range(3, 12);
            g   = 2 * SETTLE + 2 * lat + 2;
            p   = (it == 0) ? 0 : (it == 1) ? 1 : $urandom_range(2, g - 1);
            conv_len = lat; rand_data = 1; glitch = 1;
            period_cfg = PW'(p); enable = 1'b1;
            wait_pulses(3, 4 * g + 40);
            n_checks++;
            if (pulse_cyc.size() < 3) $display("FAIL minper_pulses[p=%0d] got %0d want 3", p, pulse_cyc.size());
            else n_pass++;
            if (pulse_cyc.size() >= 3) begin
                for (int k = 1; k < 3; k++) begin
                    n_checks++;
                    if (pulse_cyc[k] - pulse_cyc[k-1] != exp_gap(p, lat))
                        $display("FAIL minper_gap[p=%0d lat=%0d] got %0d want %0d", p, lat, pulse_cyc[k] - pulse_cyc[k-1], exp_gap(p, lat));
                    else n_pass++;
                end
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (pulse_v[k] !== pulse_ev[k] || pulse_i[k] !== pulse_ei[k] || pulse_n[k] != k + 1)
                        $display("FAIL minper_pair[%0d] got %0d/%0d #%0d want %0d/%0d #%0d", k, pulse_v[k], pulse_i[k], pulse_n[k], pulse_ev[k], pulse_ei[k], k + 1);
                    else n_pass++;
                end
            end
            glitch = 0;
        end
    endtask

    task automatic test_timeout();
        logic [AW-1:0] v0, i0;
        int b, tcyc, icyc;
        int vst[$];
        do_reset();
        conv_len = 10; rand_data = 1; period_cfg = 16'd100; enable = 1'b1;
        wait_pulses(1, 200);
        n_checks++;
        if (pulse_cyc.size() < 1 || timeout_err !== 1'b0)
            $display("FAIL tmo_first_pair got pulses=%0d err=%b want 1/0", pulse_cyc.size(), timeout_err);
        else n_pass++;
        v0 = vdd_sample; i0 = idd_sample;
        idd_never = 1;
        b = 300;
        while (timeout_err !== 1'b1 && b > 0) begin
            @(negedge clk);
            b--;
        end
        tcyc = cyc;
        icyc = start_cyc[start_cyc.size() - 1];
        n_checks++;
        if (b == 0 || start_chan[start_chan.size() - 1] !== 1'b1 || tcyc - icyc != TMO)
            $display("FAIL tmo_latency got %0d want %0d", tcyc - icyc, TMO);
        else n_pass++;
        n_checks++;
        if (pulse_cyc.size() != 1 || vdd_sample !== v0 || idd_sample !== i0)
            $display("FAIL tmo_hold got pulses=%0d %0d/%0d want 1 %0d/%0d", pulse_cyc.size(), vdd_sample, idd_sample, v0, i0);
        else n_pass++;
        idd_never = 0;
        wait_pulses(2, 300);
        n_checks++;
        if (pulse_cyc.size() < 2) $display("FAIL tmo_retry_pulses got %0d want 2", pulse_cyc.size());
        else if (pulse_cyc[1] - pulse_cyc[0] != 200 || pulse_n[1] != 2 || pulse_v[1] !== pulse_ev[1] || pulse_i[1] !== pulse_ei[1])
            $display("FAIL tmo_retry got gap=%0d #%0d %0d/%0d want 200 #2 %0d/%0d", pulse_cyc[1] - pulse_cyc[0], pulse_n[1], pulse_v[1], pulse_i[1], pulse_ev[1], pulse_ei[1]);
        else n_pass++;
        foreach (start_cyc[k]) if (start_chan[k] === 1'b0) vst.push_back(start_cyc[k]);
        n_checks++;
        if (vst.size() < 3 || vst[1] - vst[0] != 100 || vst[2] - vst[1] != 100)
            $display("FAIL tmo_v_starts got n=%0d want 3 starts 100 apart", vst.size());
        else n_pass++;
        n_checks++;
        if (timeout_err !== 1'b1) $display("FAIL tmo_sticky got %b want 1", timeout_err);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        int b;
        do_reset();
        conv_len = 10; rand_data = 1; period_cfg = 16'd40; enable = 1'b1;
        b = 100;
        while (adc_start !== 1'b1 && b > 0) begin
            @(negedge clk);
            b--;
        end
        enable = 1'b0;
        b = 200;
        while (busy !== 1'b0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        n_checks++;
        if (b == 0) $display("FAIL drop_idle got busy=%b want 0", busy);
        else n_pass++;
        repeat (50) @(negedge clk);
        n_checks++;
        if (pulse_cyc.size() != 1 || start_cyc.size() != 2 || busy !== 1'b0 || sample_count !== 16'd1)
            $display("FAIL drop_once got pulses=%0d starts=%0d busy=%b cnt=%0d want 1/2/0/1", pulse_cyc.size(), start_cyc.size(), busy, sample_count);
        else n_pass++;
        n_checks++;
        if (pulse_cyc.size() >= 1 && (pulse_v[0] !== pulse_ev[0] || pulse_i[0] !== pulse_ei[0]))
            $display("FAIL drop_pair got %0d/%0d want %0d/%0d", pulse_v[0], pulse_i[0], pulse_ev[0], pulse_ei[0]);
        else n_pass++;
    endtask

    task automatic test_err_clr();
        int b;
        do_reset();
        conv_len = 10; rand_data = 0; period_cfg = '0; idd_never = 1; enable = 1'b1;
        b = 200;
        while (timeout_err !== 1'b1 && b > 0) begin
            @(negedge clk);
            b--;
        end
        n_checks++;
        if (b == 0) $display("FAIL errclr_first got %b want 1", timeout_err);
        else n_pass++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL errclr_alone got %b want 0", timeout_err);
        else n_pass++;
        b = 200;
        while (!(adc_start === 1'b1 && adc_chan === 1'b1) && b > 0) begin
            @(negedge clk);
            b--;
        end
        repeat (TMO - 1) @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL errclr_pre got %b want 0", timeout_err);
        else n_pass++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b1 || pulse_cyc.size() != 0)
            $display("FAIL errclr_set_wins got err=%b pulses=%0d want 1/0", timeout_err, pulse_cyc.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_conv();
        int b;
        do_reset();
        conv_len = 10; rand_data = 1; period_cfg = '0; enable = 1'b1;
        wait_pulses(1, 200);
        idd_never = 1;
        b = 100;
        while (!(adc_start === 1'b1 && adc_chan === 1'b1) && b > 0) begin
            @(negedge clk);
            b--;
        end
        repeat (5) @(negedge clk);
        tb_owns_done = 1; adc_done = 1'b0; rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        clear_mon();
        n_checks++;
        if ({adc_chan, adc_start, sample_valid, busy, timeout_err, vdd_sample, idd_sample, sample_count} !== '0)
            $display("FAIL rstmid_zero got ctl=%b %h/%h cnt=%0d want 0", {adc_chan, adc_start, sample_valid, busy, timeout_err}, vdd_sample, idd_sample, sample_count);
        else n_pass++;
        rst = 1'b0; adc_done = 1'b1; adc_data = AW'($urandom);
        @(negedge clk);
        adc_done = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (pulse_cyc.size() != 0 || start_cyc.size() != 0 || busy !== 1'b0 || sample_count !== 16'd0 || vdd_sample !== '0 || idd_sample !== '0)
            $display("FAIL rstmid_late_done got pulses=%0d starts=%0d busy=%b cnt=%0d %h/%h want all 0", pulse_cyc.size(), start_cyc.size(), busy, sample_count, vdd_sample, idd_sample);
        else n_pass++;
        tb_owns_done = 0; idd_never = 0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_min_period();
        test_timeout();
        test_enable_drop();
        test_err_clr();
        test_reset_mid_conv();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
